wormhole_port_allocator: RTL and testbench

Output-port allocator for the five-port (L, N, E, W, S) NoC router. It shares one output link and crossbar column between the five input ports. A port holds the link from its head flit through its tail flit. New packets are admitted in round-robin order. Downstream buffer space is tracked with credits, and a watchdog releases a stalled owner.

---
 rtl/noc_pkg.sv | 28 ++
 rtl/rr_pick.sv | 29 ++
 rtl/wormhole_port_allocator.sv | 120 ++++++++++++
 tb/tb_wormhole_port_allocator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, flit-type codes and allocator states.
package noc_pkg;

  localparam int unsigned NPORTS = 5;

  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_N = 1;
  localparam int unsigned PORT_E = 2;
  localparam int unsigned PORT_W = 3;
  localparam int unsigned PORT_S = 4;

  localparam logic [2:0] FLIT_HEAD = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Port index reached by stepping 'step' places past 'base', wrapping over NPORTS.
  function automatic logic [2:0] port_wrap(input logic [2:0] base, input int unsigned step);
    int unsigned sum;
    sum = {29'd0, base} + step;
    return 3'(sum % NPORTS);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first candidate found searching from i_ptr+1 with wrap.
module rr_pick
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] i_cand,
  input  logic [2:0]        i_ptr,
  output logic [NPORTS-1:0] o_win,
  output logic [2:0]        o_idx,
  output logic              o_valid
);

  logic [2:0] w_probe;

  always_comb begin
    o_win   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_probe = '0;
    for (int unsigned k = 1; k <= NPORTS; k++) begin
      w_probe = port_wrap(i_ptr, k);
      if (!o_valid && i_cand[w_probe]) begin
        o_win[w_probe] = 1'b1;
        o_idx          = w_probe;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_port_allocator.sv
// Wormhole output-port allocator: round-robin packet admission, credit flow control and
// a stall watchdog that evicts an owner that stops sending.
module wormhole_port_allocator
  import noc_pkg::*;
#(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned TO_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORTS-1:0]     req,
  input  logic [3*NPORTS-1:0]   flit_id,
  input  logic [TO_W-1:0]       timeout_len,
  input  logic                  credit_in,
  output logic [NPORTS-1:0]     grant,
  output logic [2:0]            xbar_sel,
  output logic                  fwd,
  output logic [3:0]            credits,
  output logic                  timeout_err
);

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  state_e            r_state;
  logic [2:0]        r_rr_ptr;
  logic [TO_W-1:0]   r_wd;

  logic [NPORTS-1:0] w_head;
  logic [NPORTS-1:0] w_tail;
  logic [NPORTS-1:0] w_body;
  logic              w_unused_body;
  logic [NPORTS-1:0] w_win;
  logic [2:0]        w_win_idx;
  logic              w_win_valid;
  logic [TO_W-1:0]   w_wd_inc;
  logic              w_expire;
  logic              w_tail_fwd;

  always_comb begin
    w_head = '0;
    w_tail = '0;
    w_body = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      w_head[i] = req[i] & |(flit_id[3*i +: 3] & FLIT_HEAD);
      w_tail[i] = |(flit_id[3*i +: 3] & FLIT_TAIL);
      w_body[i] = |(flit_id[3*i +: 3] & FLIT_BODY);
    end
  end

  // Body bits carry no control meaning for allocation.
  assign w_unused_body = ^w_body;

  rr_pick u_rr_pick (
    .i_cand  (w_head),
    .i_ptr   (r_rr_ptr),
    .o_win   (w_win),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  assign fwd        = (r_state == BUSY) && req[xbar_sel] && (credits != '0);
  assign w_tail_fwd = fwd && w_tail[xbar_sel];

  // Watchdog fires once the stall count including this cycle reaches timeout_len.
  assign w_wd_inc = (&r_wd) ? r_wd : r_wd + 1'b1;
  assign w_expire = (r_state == BUSY) && !fwd && (timeout_len != '0) &&
                    (w_wd_inc == timeout_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      grant       <= '0;
      xbar_sel    <= '0;
      credits     <= CRED_MAX;
      r_rr_ptr    <= 3'(PORT_S);
      r_wd        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;

      if (fwd && !credit_in) begin
        credits <= credits - 4'd1;
      end else if (!fwd && credit_in && credits != CRED_MAX) begin
        credits <= credits + 4'd1;
      end

      case (r_state)
        IDLE: begin
          r_wd <= '0;
          if (w_win_valid) begin
            r_state  <= BUSY;
            grant    <= w_win;
            xbar_sel <= w_win_idx;
          end
        end
        BUSY: begin
          if (w_tail_fwd) begin
            r_state  <= IDLE;
            grant    <= '0;
            xbar_sel <= '0;
            r_rr_ptr <= xbar_sel;
            r_wd     <= '0;
          end else if (fwd) begin
            r_wd <= '0;
          end else if (w_expire) begin
            r_state     <= IDLE;
            grant       <= '0;
            xbar_sel    <= '0;
            r_rr_ptr    <= xbar_sel;
            r_wd        <= '0;
            timeout_err <= 1'b1;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wormhole_port_allocator.sv
// Scoreboard bench: the driver queues hand-computed per-cycle output snapshots, and a
// negedge monitor pops and compares them against the allocator outputs.
module tb_wormhole_port_allocator;

  localparam int unsigned CREDITS = 4;
  localparam int unsigned TO_W    = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      req;
  logic [14:0]     flit_id;
  logic [TO_W-1:0] timeout_len;
  logic            credit_in;
  logic [4:0]      grant;
  logic [2:0]      xbar_sel;
  logic            fwd;
  logic [3:0]      credits;
  logic            timeout_err;

  wormhole_port_allocator #(
    .CREDITS (CREDITS),
    .TO_W    (TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .timeout_len (timeout_len),
    .credit_in   (credit_in),
    .grant       (grant),
    .xbar_sel    (xbar_sel),
    .fwd         (fwd),
    .credits     (credits),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       fwd;
    logic [3:0] cred;
    logic       terr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc || grant !== e.grant || xbar_sel !== e.sel || fwd !== e.fwd ||
          credits !== e.cred || timeout_err !== e.terr) begin
        n_fail++;
        $display("FAIL %s cyc=%0d(exp cyc %0d): got grant=%b sel=%0d fwd=%b credits=%0d terr=%b, want grant=%b sel=%0d fwd=%b credits=%0d terr=%b",
                 e.name, cyc, e.cyc, grant, xbar_sel, fwd, credits, timeout_err,
                 e.grant, e.sel, e.fwd, e.cred, e.terr);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r, input logic [14:0] f, input logic ci);
    req       = r;
    flit_id   = f;
    credit_in = ci;
  endtask

  task automatic expect_now(input string nm, input logic [4:0] g, input logic [2:0] s,
                            input logic f, input logic [3:0] c, input logic t);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.grant = g; e.sel = s; e.fwd = f; e.cred = c; e.terr = t;
    sb.push_back(e);
  endtask

  function automatic logic [14:0] fid(input int p, input logic [2:0] t);
    logic [14:0] v;
    v = '0;
    v[3*p +: 3] = t;
    return v;
  endfunction

  function automatic logic [4:0] onehot(input int p);
    logic [4:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    next();
    rst = 1'b1;
    drive(5'b0, 15'b0, 1'b0);
    next();
    rst = 1'b0;
    expect_now("reset", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
  endtask

  // One arbitration cycle, then the whole packet of port p while 'pending' ports wait.
  task automatic serve(input int p, input logic [4:0] pending, input int nflits);
    logic [14:0] heads;
    logic [14:0] f;
    logic [2:0]  t;
    heads = '0;
    for (int i = 0; i < 5; i++) if (pending[i]) heads |= fid(i, 3'b001);
    next();
    drive(pending, heads, 1'b1);
    expect_now("rr_idle", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    for (int k = 0; k < nflits; k++) begin
      next();
      if (nflits == 1)            t = 3'b101;
      else if (k == 0)            t = 3'b001;
      else if (k == nflits - 1)   t = 3'b100;
      else                        t = 3'b010;
      f = heads;
      f[3*p +: 3] = t;
      drive(pending, f, 1'b1);
      expect_now("rr_fwd", onehot(p), 3'(p), 1'b1, 4'd4, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    timeout_len = '0;
    drive(5'b0, 15'b0, 1'b0);
    next();
    next();
    rst = 1'b0;
    expect_now("reset_init", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);

    // Single-flit packet on N
    next(); drive(5'b00010, fid(1, 3'b101), 1'b0);
    expect_now("n_idle", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    next(); expect_now("n_grant", 5'b00010, 3'd1, 1'b1, 4'd4, 1'b0);
    next(); drive(5'b0, 15'b0, 1'b1);
    expect_now("n_release", 5'b0, 3'd0, 1'b0, 4'd3, 1'b0);
    next(); drive(5'b0, 15'b0, 1'b0);
    expect_now("n_credit_back", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);

    // Round robin from reset: L, E, S
    do_reset();
    serve(0, 5'b10101, 3);
    serve(2, 5'b10100, 3);
    serve(4, 5'b10000, 3);
    // Leave rr_ptr at E, then all three contend: S, L, E
    serve(2, 5'b00100, 1);
    serve(4, 5'b10101, 3);
    serve(0, 5'b00101, 3);
    serve(2, 5'b00100, 3);
    next(); drive(5'b0, 15'b0, 1'b0);
    expect_now("rr_done", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);

    // Credit stall: 6-flit packet on W
    next(); drive(5'b01000, fid(3, 3'b001), 1'b0);
    expect_now("cs_idle", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    next(); expect_now("cs_head", 5'b01000, 3'd3, 1'b1, 4'd4, 1'b0);
    next(); drive(5'b01000, fid(3, 3'b010), 1'b0);
    expect_now("cs_b1", 5'b01000, 3'd3, 1'b1, 4'd3, 1'b0);
    next(); expect_now("cs_b2", 5'b01000, 3'd3, 1'b1, 4'd2, 1'b0);
    next(); expect_now("cs_b3", 5'b01000, 3'd3, 1'b1, 4'd1, 1'b0);
    next(); expect_now("cs_zero", 5'b01000, 3'd3, 1'b0, 4'd0, 1'b0);
    next(); drive(5'b01000, fid(3, 3'b010), 1'b1);
    expect_now("cs_zero_cin", 5'b01000, 3'd3, 1'b0, 4'd0, 1'b0);
    next(); drive(5'b01000, fid(3, 3'b010), 1'b0);
    expect_now("cs_one_fwd", 5'b01000, 3'd3, 1'b1, 4'd1, 1'b0);
    next(); drive(5'b01000, fid(3, 3'b010), 1'b1);
    expect_now("cs_zero2", 5'b01000, 3'd3, 1'b0, 4'd0, 1'b0);
    next(); drive(5'b01000, fid(3, 3'b100), 1'b1);
    expect_now("cs_tail_cin", 5'b01000, 3'd3, 1'b1, 4'd1, 1'b0);
    next(); drive(5'b0, 15'b0, 1'b1);
    expect_now("cs_simul_same", 5'b0, 3'd0, 1'b0, 4'd1, 1'b0);
    next(); expect_now("cs_inc2", 5'b0, 3'd0, 1'b0, 4'd2, 1'b0);
    next(); expect_now("cs_inc3", 5'b0, 3'd0, 1'b0, 4'd3, 1'b0);
    next(); expect_now("cs_full", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    next(); drive(5'b0, 15'b0, 1'b0);
    expect_now("cs_saturate", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);

    // Watchdog with timeout_len=3: E stalls after its head
    next(); timeout_len = 12'd3; drive(5'b00100, fid(2, 3'b001), 1'b0);
    expect_now("wd_idle", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    next(); drive(5'b00100, fid(2, 3'b001), 1'b1);
    expect_now("wd_head", 5'b00100, 3'd2, 1'b1, 4'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      next(); drive(5'b0, 15'b0, 1'b0);
      expect_now("wd_stall", 5'b00100, 3'd2, 1'b0, 4'd4, 1'b0);
    end
    next(); drive(5'b10000, fid(4, 3'b101), 1'b0);
    expect_now("wd_pulse", 5'b0, 3'd0, 1'b0, 4'd4, 1'b1);
    next(); drive(5'b10000, fid(4, 3'b101), 1'b1);
    expect_now("wd_next_s", 5'b10000, 3'd4, 1'b1, 4'd4, 1'b0);
    next(); drive(5'b0, 15'b0, 1'b0);
    expect_now("wd_s_done", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);

    // Watchdog disabled
    next(); timeout_len = '0; drive(5'b00100, fid(2, 3'b001), 1'b0);
    expect_now("wd0_idle", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    next(); drive(5'b00100, fid(2, 3'b001), 1'b1);
    expect_now("wd0_head", 5'b00100, 3'd2, 1'b1, 4'd4, 1'b0);
    for (int k = 0; k < 100; k++) begin
      next(); drive(5'b0, 15'b0, 1'b0);
      expect_now("wd0_hold", 5'b00100, 3'd2, 1'b0, 4'd4, 1'b0);
    end
    next(); drive(5'b00100, fid(2, 3'b100), 1'b1);
    expect_now("wd0_tail", 5'b00100, 3'd2, 1'b1, 4'd4, 1'b0);
    next(); drive(5'b0, 15'b0, 1'b0);
    expect_now("wd0_done", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);

    // Non-head request in IDLE is ignored
    for (int k = 0; k < 3; k++) begin
      next(); drive(5'b00010, fid(1, 3'b010), 1'b0);
      expect_now("nohead", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    end

    // Reset in the middle of a packet on L
    next(); drive(5'b00001, fid(0, 3'b001), 1'b0);
    expect_now("rst_idle", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    next(); expect_now("rst_head", 5'b00001, 3'd0, 1'b1, 4'd4, 1'b0);
    next(); drive(5'b00001, fid(0, 3'b010), 1'b0); rst = 1'b1;
    expect_now("rst_body", 5'b00001, 3'd0, 1'b1, 4'd3, 1'b0);
    next(); rst = 1'b0; drive(5'b0, 15'b0, 1'b0);
    expect_now("rst_mid", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    next(); drive(5'b00110, fid(1, 3'b101) | fid(2, 3'b001), 1'b0);
    expect_now("post_rst_idle", 5'b0, 3'd0, 1'b0, 4'd4, 1'b0);
    next(); expect_now("post_rst_n", 5'b00010, 3'd1, 1'b1, 4'd4, 1'b0);
    next(); drive(5'b0, 15'b0, 1'b0);
    expect_now("post_rst_done", 5'b0, 3'd0, 1'b0, 4'd3, 1'b0);

    next();
    next();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
